// File: rtl/multdiv_ctrl.sv
// Multiply/divide unit controller: pipelined-latency multiply and accumulate,
// radix-2 restoring divide with signed fixup, flushable, HI/LO result registers.
module multdiv_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'd32;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        accept, in_signed, is_signed, sign_a, sign_b;
    logic [63:0] ext_a, ext_b, prod, acc, mul_res;
    logic [32:0] partial, diff;
    logic [31:0] q_fix, r_fix;

    assign accept    = (state_q == S_IDLE) && start && !flush;
    assign in_signed = ~op[0];
    assign is_signed = ~op_q[0];
    assign sign_a    = is_signed & a_q[31];
    assign sign_b    = is_signed & b_q[31];

    assign ext_a   = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign ext_b   = is_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod    = ext_a * ext_b;
    assign acc     = {acc_hi_q, acc_lo_q};
    assign mul_res = !op_q[2] ? prod : (op_q[1] ? acc - prod : acc + prod);

    // Divide step: shift one dividend bit into the partial remainder and try a subtract.
    assign partial = {rem_q, quo_q[31]};
    assign diff    = partial - {1'b0, dvs_q};
    assign q_fix   = (sign_a ^ sign_b) ? -quo_q : quo_q;
    assign r_fix   = sign_a ? -rem_q : rem_q;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (op[2:1] == 2'b01) ? S_DIV : S_MUL;
            S_MUL:  if (flush) state_d = S_IDLE; else if (cnt_q == MUL_LAST) state_d = S_DONE;
            S_DIV:  if (flush) state_d = S_IDLE; else if (cnt_q == DIV_LAST) state_d = S_FIX;
            S_FIX:  state_d = flush ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = '0;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE: if (accept) begin
                cnt_d    = 6'd1;
                op_d     = op;
                a_d      = a;
                b_d      = b;
                acc_hi_d = hi_in;
                acc_lo_d = lo_in;
                quo_d    = (in_signed && a[31]) ? -a : a;
                rem_d    = '0;
                dvs_d    = (in_signed && b[31]) ? -b : b;
            end
            S_MUL: if (!flush) begin
                if (cnt_q == MUL_LAST) {hi_d, lo_d} = mul_res;
                else cnt_d = cnt_q + 6'd1;
            end
            S_DIV: if (!flush) begin
                if (cnt_q != DIV_LAST) cnt_d = cnt_q + 6'd1;
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = partial[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
            end
            S_FIX: if (!flush) begin
                if (b_q == '0) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = r_fix;
                    lo_d = q_fix;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
        done   = (state_q == S_DONE);
        hi_out = hi_q;
        lo_out = lo_q;
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: directed corner cases plus random ops
// compared against an arithmetic reference model, with flush and reset scenarios.
module tb_multdiv_ctrl;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0, hi_in = '0, lo_in = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    multdiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] res;
    } vec_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [63:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("hi_out", {32'b0, hi_out}, {32'b0, e.hi});
                check("lo_out", {32'b0, lo_out}, {32'b0, e.lo});
            end
        end
    end

    function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma, mb, mhi, mlo);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, p, accv;
        logic [31:0] q, r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'b0, ma};
        ub = {32'b0, mb};
        if (mop == 3'd2 || mop == 3'd3) begin
            if (mb == 0) return {ma, 32'hFFFF_FFFF};
            if (mop == 3'd2) begin
                sq = sa / sb;
                sr = sa % sb;
                q = sq[31:0];
                r = sr[31:0];
            end else begin
                q = 32'(ua / ub);
                r = 32'(ua % ub);
            end
            return {r, q};
        end
        p = mop[0] ? ua * ub : 64'(sa * sb);
        accv = {mhi, mlo};
        if (mop == 3'd4 || mop == 3'd5) return accv + p;
        if (mop == 3'd6 || mop == 3'd7) return accv - p;
        return p;
    endfunction

    function automatic int latency(input logic [2:0] lop);
        return (lop == 3'd2 || lop == 3'd3) ? DIV_LAT : MUL_LAT;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 64'(n), 64'd0);
    endtask

    // Drives one accept cycle starting now (just after an edge); leaves us one cycle later.
    task automatic issue_raw(input logic [2:0] iop, input logic [31:0] ia, ib, ihi, ilo,
                             input logic [63:0] res, input bit push, output int t);
        op = iop; a = ia; b = ib; hi_in = ihi; lo_in = ilo;
        start = 1'b1;
        t = cyc;
        #1;
        check("busy_in_accept", {63'b0, busy}, 64'd0);
        if (push) begin
            sb_q.push_back('{hi: res[63:32], lo: res[31:0], cyc: t + latency(iop)});
            last_res = res;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic issue(input logic [2:0] iop, input logic [31:0] ia, ib, ihi, ilo,
                         input logic [63:0] res);
        int t;
        wait_idle();
        issue_raw(iop, ia, ib, ihi, ilo, res, 1'b1, t);
    endtask

    vec_t dir[9];

    initial begin
        int          t;
        logic [2:0]  rop;
        logic [31:0] ra, rb, rhi, rlo;
        int          n;

        dir[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFE};
        dir[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 64'h0000_0001_FFFF_FFFE};
        dir[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD};
        dir[3] = '{3'd3, 32'd7, 32'd2, 32'd0, 32'd0, 64'h0000_0001_0000_0003};
        dir[4] = '{3'd2, 32'd5, 32'd0, 32'd0, 32'd0, 64'h0000_0005_FFFF_FFFF};
        dir[5] = '{3'd3, 32'd5, 32'd0, 32'd0, 32'd0, 64'h0000_0005_FFFF_FFFF};
        dir[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'h0000_0000_8000_0000};
        dir[7] = '{3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000};
        dir[8] = '{3'd6, 32'd1, 32'd1, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_hi", {32'b0, hi_out}, 64'd0);
        check("reset_lo", {32'b0, lo_out}, 64'd0);
        rst = 1'b0;

        // First accept happens on the first edge after reset release.
        foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, dir[i].hi, dir[i].lo, dir[i].res);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            rhi = $urandom;
            rlo = $urandom;
            issue(rop, ra, rb, rhi, rlo, model(rop, ra, rb, rhi, rlo));
        end

        // Flush a divide at T+10; restart at T+11; a start while busy is ignored.
        wait_idle();
        issue_raw(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 64'd0, 1'b0, t);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_drop", {63'b0, busy}, 64'd0);
        check("flush_hold_hi", {32'b0, hi_out}, {32'b0, last_res[63:32]});
        check("flush_hold_lo", {32'b0, lo_out}, {32'b0, last_res[31:0]});
        issue_raw(3'd1, 32'd6, 32'd7, 32'd0, 32'd0, 64'd42, 1'b1, t);
        check("restart_busy", {63'b0, busy}, 64'd1);
        op = 3'd2; a = 32'd9; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (DIV_LAT + 4) @(posedge clk);
        #1;

        // start together with flush in IDLE is ignored.
        op = 3'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("start_with_flush_ignored", {63'b0, busy}, 64'd0);

        // Flush during DONE must not suppress the pulse.
        issue_raw(3'd0, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, t);
        repeat (MUL_LAT - 1) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        wait_idle();
        issue_raw(3'd0, 32'd11, 32'd13, 32'd0, 32'd0, 64'd0, 1'b0, t);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", {63'b0, busy}, 64'd0);
        check("async_rst_done", {63'b0, done}, 64'd0);
        check("async_rst_hi", {32'b0, hi_out}, 64'd0);
        check("async_rst_lo", {32'b0, lo_out}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_res = '0;
        repeat (MUL_LAT + 4) @(posedge clk);
        #1;
        issue(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF,
              model(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF));

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
